// File: rtl/lock_manager_pkg.sv
// Shared constants, codes and types for the hardware-runtime lock service.
package lock_manager_pkg;
  localparam int LOCK_ID_BITS     = 8;
  localparam int LOCK_TABLE_DEPTH = 2**LOCK_ID_BITS;
  localparam int LOCK_ID_L        = 8;
  localparam int LOCK_ID_H        = LOCK_ID_L + LOCK_ID_BITS - 1;

  localparam int ACK_CODE_L   = 0;
  localparam int ACK_CODE_H   = 7;
  localparam int ACK_LOCKID_L = 8;
  localparam int ACK_LOCKID_H = 15;

  localparam logic [7:0] CMD_LOCK_CODE   = 8'h04;
  localparam logic [7:0] CMD_UNLOCK_CODE = 8'h06;
  localparam logic [7:0] ACK_OK_CODE     = 8'h01;
  localparam logic [7:0] ACK_REJECT_CODE = 8'h00;

  typedef enum logic [1:0] {LK_IDLE, LK_EXEC, LK_ACK} lock_state_t;

  typedef struct packed {
    logic [7:0]              code;
    logic [LOCK_ID_BITS-1:0] id;
    logic                    last;
  } lock_cmd_t;

  function automatic logic [63:0] make_ack(input logic [7:0] code,
                                           input logic [LOCK_ID_BITS-1:0] id);
    logic [63:0] a;
    a = '0;
    a[ACK_CODE_H:ACK_CODE_L]     = code;
    a[ACK_LOCKID_H:ACK_LOCKID_L] = 8'(id);
    return a;
  endfunction
endpackage

// File: rtl/lock_manager_table.sv
// Lock table: locked bitmap plus per-lock owner id, one combinational read port, one write port.
module lock_table
  import lock_manager_pkg::*;
#(
  parameter int ACC_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [LOCK_ID_BITS-1:0] rd_id,
  output logic                    rd_locked,
  output logic [ACC_BITS-1:0]     rd_owner,
  input  logic                    wr_en,
  input  logic                    wr_set,
  input  logic [LOCK_ID_BITS-1:0] wr_id,
  input  logic [ACC_BITS-1:0]     wr_owner
);
  logic [LOCK_TABLE_DEPTH-1:0]               locked_q;
  logic [LOCK_TABLE_DEPTH-1:0][ACC_BITS-1:0] owner_q;

  // A clear only drops the bit; the stale owner is meaningless while unlocked.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      locked_q <= '0;
      owner_q  <= '0;
    end else if (wr_en) begin
      locked_q[wr_id] <= wr_set;
      if (wr_set) owner_q[wr_id] <= wr_owner;
    end
  end

  assign rd_locked = locked_q[rd_id];
  assign rd_owner  = owner_q[rd_id];
endmodule

// File: rtl/lock_manager.sv
// Lock service top: serialising IDLE/EXEC/ACK FSM, command and ack registers, error counter.
module lock_manager
  import lock_manager_pkg::*;
#(
  parameter int ACC_BITS = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [63:0]         inStream_tdata,
  input  logic                inStream_tvalid,
  output logic                inStream_tready,
  input  logic [ACC_BITS-1:0] inStream_tid,
  input  logic                inStream_tlast,
  output logic [63:0]         outStream_tdata,
  output logic                outStream_tvalid,
  input  logic                outStream_tready,
  output logic [ACC_BITS-1:0] outStream_tdest,
  output logic                outStream_tlast,
  output logic [15:0]         err_count
);
  lock_state_t         state_q, state_d;
  lock_cmd_t           cmd_q;
  logic [ACC_BITS-1:0] tid_q;
  logic                run_q;
  logic                in_hs;
  logic                tbl_locked;
  logic [ACC_BITS-1:0] tbl_owner;
  logic                tbl_wr, tbl_set, ack_ld, err_inc;
  logic [7:0]          ack_code;
  logic                unused_bits;

  assign unused_bits = ^inStream_tdata[63:LOCK_ID_H+1];

  // run_q keeps tready low while reset is asserted and for the first cycle after.
  assign inStream_tready  = (state_q == LK_IDLE) & run_q;
  assign in_hs            = inStream_tvalid & inStream_tready;
  assign outStream_tvalid = (state_q == LK_ACK);
  assign outStream_tlast  = 1'b1;

  lock_table #(.ACC_BITS(ACC_BITS)) u_table (
    .clk      (clk),
    .rstn     (rstn),
    .rd_id    (cmd_q.id),
    .rd_locked(tbl_locked),
    .rd_owner (tbl_owner),
    .wr_en    (tbl_wr),
    .wr_set   (tbl_set),
    .wr_id    (cmd_q.id),
    .wr_owner (tid_q)
  );

  always_comb begin
    state_d  = state_q;
    tbl_wr   = 1'b0;
    tbl_set  = 1'b0;
    ack_ld   = 1'b0;
    ack_code = ACK_REJECT_CODE;
    err_inc  = 1'b0;
    case (state_q)
      LK_IDLE: if (in_hs) state_d = LK_EXEC;
      LK_EXEC: begin
        state_d = LK_IDLE;
        if (cmd_q.last && cmd_q.code == CMD_LOCK_CODE) begin
          ack_ld  = 1'b1;
          state_d = LK_ACK;
          if (!tbl_locked) begin
            tbl_wr   = 1'b1;
            tbl_set  = 1'b1;
            ack_code = ACK_OK_CODE;
          end
        end else if (cmd_q.last && cmd_q.code == CMD_UNLOCK_CODE &&
                     tbl_locked && tbl_owner == tid_q) begin
          tbl_wr = 1'b1;
        end else begin
          err_inc = 1'b1;
        end
      end
      LK_ACK:  if (outStream_tready) state_d = LK_IDLE;
      default: state_d = LK_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= LK_IDLE;
      run_q           <= 1'b0;
      cmd_q           <= '0;
      tid_q           <= '0;
      outStream_tdata <= '0;
      outStream_tdest <= '0;
      err_count       <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (in_hs) begin
        cmd_q <= '{code: inStream_tdata[7:0],
                   id:   inStream_tdata[LOCK_ID_H:LOCK_ID_L],
                   last: inStream_tlast};
        tid_q <= inStream_tid;
      end
      if (ack_ld) begin
        outStream_tdata <= make_ack(ack_code, cmd_q.id);
        outStream_tdest <= tid_q;
      end
      if (err_inc && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_lock_manager.sv
// Directed bench for lock_manager: abstract lock-table model, per-cycle output compare, literal pins.
module tb_lock_manager;
  logic        clk = 1'b0;
  logic        rstn;
  logic [63:0] inStream_tdata;
  logic        inStream_tvalid;
  logic        inStream_tready;
  logic [3:0]  inStream_tid;
  logic        inStream_tlast;
  logic [63:0] outStream_tdata;
  logic        outStream_tvalid;
  logic        outStream_tready;
  logic [3:0]  outStream_tdest;
  logic        outStream_tlast;
  logic [15:0] err_count;

  lock_manager #(.ACC_BITS(4)) dut (
    .clk(clk), .rstn(rstn),
    .inStream_tdata(inStream_tdata), .inStream_tvalid(inStream_tvalid),
    .inStream_tready(inStream_tready), .inStream_tid(inStream_tid),
    .inStream_tlast(inStream_tlast),
    .outStream_tdata(outStream_tdata), .outStream_tvalid(outStream_tvalid),
    .outStream_tready(outStream_tready), .outStream_tdest(outStream_tdest),
    .outStream_tlast(outStream_tlast), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  dest;
    int          cyc;
  } exp_t;
  exp_t expq[$];

  bit          m_locked[256];
  int          m_owner[256];
  int          m_err = 0;
  bit          seen = 0;
  logic [63:0] last_data;
  logic [3:0]  last_dest;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] cmd(input logic [7:0] code, input logic [7:0] id);
    return {48'h0, id, code};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      m_locked[i] = 0;
      m_owner[i]  = 0;
    end
    m_err = 0;
    expq.delete();
    seen = 0;
  endtask

  // Apply one accepted command to the abstract table; LOCKs queue the expected ack.
  task automatic model_apply(input logic [63:0] d, input logic [3:0] t, input logic l,
                             input int hs);
    exp_t e;
    int   id;
    id = int'(d[15:8]);
    if (l && d[7:0] == 8'h04) begin
      e.dest = t;
      e.cyc  = hs + 2;
      if (m_locked[id]) e.data = {48'h0, d[15:8], 8'h00};
      else begin
        m_locked[id] = 1;
        m_owner[id]  = int'(t);
        e.data       = {48'h0, d[15:8], 8'h01};
      end
      expq.push_back(e);
    end else if (l && d[7:0] == 8'h06 && m_locked[id] && m_owner[id] == int'(t)) begin
      m_locked[id] = 0;
    end else if (m_err < 65535) begin
      m_err++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic [3:0] t, input logic l);
    int n;
    n = 0;
    inStream_tdata  = d;
    inStream_tid    = t;
    inStream_tlast  = l;
    inStream_tvalid = 1'b1;
    @(negedge clk);
    while (!inStream_tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept_timeout", {63'h0, inStream_tready}, 64'h1);
    if (!inStream_tready) begin
      inStream_tvalid = 1'b0;
      return;
    end
    tick();
    inStream_tvalid = 1'b0;
    model_apply(d, t, l, cyc - 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || !inStream_tready) && n < 100) begin
      tick();
      n++;
    end
    chk("drain_timeout", {63'h0, n < 100}, 64'h1);
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rstn) begin
      if (outStream_tvalid) begin
        if (expq.size() == 0) chk("unexpected_ack", outStream_tdata, 64'hDEAD);
        else begin
          chk("ack_data", outStream_tdata, expq[0].data);
          chk("ack_dest", {60'h0, outStream_tdest}, {60'h0, expq[0].dest});
          chk("ack_tlast", {63'h0, outStream_tlast}, 64'h1);
          chk("tready_in_ack", {63'h0, inStream_tready}, 64'h0);
          if (!seen) begin
            chk("ack_latency", 64'(cyc), 64'(expq[0].cyc));
            seen = 1;
          end
          if (outStream_tready) begin
            last_data = outStream_tdata;
            last_dest = outStream_tdest;
            void'(expq.pop_front());
            seen = 0;
          end
        end
      end else if (inStream_tready) begin
        chk("err_count", {48'h0, err_count}, 64'(m_err));
        chk("missing_ack", 64'(expq.size()), 64'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rstn = 1'b0;
    inStream_tdata = '0; inStream_tvalid = 1'b0; inStream_tid = '0; inStream_tlast = 1'b1;
    outStream_tready = 1'b1;
    model_reset();
    repeat (3) tick();
    chk("rst_in_tready", {63'h0, inStream_tready}, 64'h0);
    chk("rst_out_tvalid", {63'h0, outStream_tvalid}, 64'h0);
    chk("rst_out_tdata", outStream_tdata, 64'h0);
    chk("rst_out_tdest", {60'h0, outStream_tdest}, 64'h0);
    chk("rst_err", {48'h0, err_count}, 64'h0);
    rstn = 1'b1;
    tick();

    // 1: first lock
    send(cmd(8'h04, 8'h05), 4'd2, 1'b1); drain();
    chk("t1_data", last_data, 64'h0501);
    chk("t1_dest", {60'h0, last_dest}, 64'h2);

    // 2: contention, bad unlock, good unlock, relock
    send(cmd(8'h04, 8'h05), 4'd3, 1'b1); drain();
    chk("t2_reject", last_data, 64'h0500);
    chk("t2_reject_dest", {60'h0, last_dest}, 64'h3);
    send(cmd(8'h06, 8'h05), 4'd3, 1'b1); drain();
    chk("t2_err1", {48'h0, err_count}, 64'h1);
    send(cmd(8'h06, 8'h05), 4'd2, 1'b1); drain();
    send(cmd(8'h04, 8'h05), 4'd3, 1'b1); drain();
    chk("t2_relock", last_data, 64'h0501);
    chk("t2_relock_dest", {60'h0, last_dest}, 64'h3);

    // 3: ten-cycle backpressure
    outStream_tready = 1'b0;
    send(cmd(8'h04, 8'h20), 4'd6, 1'b1);
    repeat (12) tick();
    chk("t3_stall_valid", {63'h0, outStream_tvalid}, 64'h1);
    chk("t3_stall_tready", {63'h0, inStream_tready}, 64'h0);
    outStream_tready = 1'b1;
    drain();
    chk("t3_data", last_data, 64'h2001);

    // 4: illegal code and tlast=0 dropped
    send(cmd(8'h07, 8'h07), 4'd1, 1'b1);
    send(cmd(8'h04, 8'h07), 4'd1, 1'b0);
    drain();
    chk("t4_err3", {48'h0, err_count}, 64'h3);
    send(cmd(8'h04, 8'h07), 4'd1, 1'b1); drain();
    chk("t4_lock_ok", last_data, 64'h0701);

    // 5: id boundaries and upper-bit aliasing
    send(cmd(8'h04, 8'h00), 4'd4, 1'b1);
    send(cmd(8'h04, 8'hFF), 4'd5, 1'b1); drain();
    chk("t5_id255", last_data, 64'hFF01);
    chk("t5_id255_dest", {60'h0, last_dest}, 64'h5);
    send(64'hDEAD_BEEF_1234_0004, 4'd7, 1'b1); drain();
    chk("t5_alias_reject_dest", {60'h0, last_dest}, 64'h7);
    send(64'hA5A5_0000_0003_FF06, 4'd5, 1'b1);
    send(64'h8000_0000_0001_FF04, 4'd4, 1'b1); drain();
    chk("t5_alias_relock", last_data, 64'hFF01);
    chk("t5_err", {48'h0, err_count}, 64'h3);

    // 6: reset while an ack is pending
    outStream_tready = 1'b0;
    send(cmd(8'h04, 8'h09), 4'd8, 1'b1);
    n = 0;
    while (!outStream_tvalid && n < 20) begin tick(); n++; end
    chk("t6_reach_ack", {63'h0, outStream_tvalid}, 64'h1);
    rstn = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_valid", {63'h0, outStream_tvalid}, 64'h0);
    chk("t6_rst_tdata", outStream_tdata, 64'h0);
    chk("t6_rst_err", {48'h0, err_count}, 64'h0);
    outStream_tready = 1'b1;
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    send(cmd(8'h04, 8'h09), 4'd8, 1'b1); drain();
    chk("t6_relock", last_data, 64'h0901);
    chk("t6_err0", {48'h0, err_count}, 64'h0);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
